sw_mem_write: RTL and testbench
===============================

Name: sw_mem_write

Overview:
- Board-input loader that writes words into data memory. It is the write-side counterpart of the LCD memory reader, which reads data memory out to the LCD.
- The operator sets an 8-bit byte on the switches and presses a key. Four presses assemble one 32-bit word, MSB byte first.
- The assembled word is written to data memory through a request/ack port toward the memory arbiter. The write address then advances by one word.
- The block sits beside the LCD reader at the data-memory boundary of the datapath.

Parameters:
- ADDR_WIDTH, 32, width of the data-memory word address.
- DATA_WIDTH, 32, width of the data-memory word; must equal 4*8.
- ADDR_BASE, 0, first word address written after reset.
- ADDR_LIMIT, 255, last word address; the next address after it wraps to ADDR_BASE.

Ports:
- clk  input  1  system clock (50 MHz).
- rst  input  1  synchronous reset, active-high.
- write_in_n  input  1  raw key, active-low, asynchronous to clk.
- sw_in  input  8  switch byte, sampled on the accepted key edge.
- clear_in  input  1  synchronous pulse: drop partial bytes, address back to ADDR_BASE.
- addr_out  output  ADDR_WIDTH  data-memory word address.
- data_out  output  DATA_WIDTH  data-memory write data.
- data_mem_wr_en_out  output  1  write request, held until ack.
- data_mem_wr_ack_in  input  1  arbiter grant; the write is complete in the cycle ack=1 with request=1.
- byte_cnt_out  output  2  bytes collected toward the current word.
- busy_out  output  1  high while a write request is outstanding.
- word_done_out  output  1  one-cycle pulse when a write is acknowledged.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high, names clk and rst. On reset, every output, synchronizer flop and state register clears in the same edge.
- Reset values:
  - addr_out = ADDR_BASE; data_out = 0; byte_cnt_out = 0.
  - data_mem_wr_en_out = 0; busy_out = 0; word_done_out = 0.
  - State = COLLECT.
- Key input:
  - write_in_n passes through a 2-flop synchronizer, then is inverted.
  - A press is a rising edge of the synchronized, inverted level.
  - Latency from the key input to an accepted edge is 3 clocks.
  - No debounce filter; bounce produces extra bytes by design.
- States: COLLECT, WRITE.
- COLLECT state:
  - On a press, sw_in is shifted into shift_reg[7:0] and the older bytes move up: shift_reg <= {shift_reg[23:0], sw_in}.
  - byte_cnt increments by 1.
  - When the press brings the count to 4:
    - data_out <= the assembled word.
    - byte_cnt <= 0.
    - data_mem_wr_en_out <= 1 and busy_out <= 1 in the next cycle.
    - Go to WRITE.
- WRITE state:
  - addr_out and data_out are held stable while the request is high.
  - In the cycle ack=1:
    - Next cycle: data_mem_wr_en_out = 0, busy_out = 0, word_done_out = 1 for exactly 1 cycle.
    - addr_out advances by 1; if it was ADDR_LIMIT it wraps to ADDR_BASE.
    - Return to COLLECT.
  - Ack in the same cycle the request rises counts; minimum write occupancy is 1 cycle.
- Presses during WRITE are ignored; they are not queued.
- Ack while in COLLECT, or with the request low, is ignored.
- clear_in:
  - In COLLECT: byte_cnt = 0, shift_reg = 0, addr_out = ADDR_BASE.
  - In WRITE: ignored until the write completes.
- Simultaneous events:
  - clear_in and a press in the same COLLECT cycle: clear wins and the byte is dropped.
  - rst over anything: rst wins.
- Reset mid-write: the request drops on the next edge. No word_done_out pulse, and the address is not advanced.

Decomposition:
- Shared package (sw_mem_pkg):
  - State enum: COLLECT=1'b0, WRITE=1'b1.
  - BYTES_PER_WORD = 4.
  - Default ADDR_WIDTH/DATA_WIDTH constants, shared with the LCD reader.
- One sub-module: key_sync_edge.
  - Contents: 2-flop synchronizer, active-low inversion, rising-edge pulse.
  - Same clk/rst.
  - Reusable for the LCD reader's read_in key.

Test Plan:
- Basic word: reset, then presses with sw_in = 8'h12, 34, 56, 78 → data_mem_wr_en_out rises with addr_out=0, data_out=32'h12345678. Ack after 2 cycles → word_done_out one pulse; addr_out=1; byte_cnt_out=0.
- Wrap: ADDR_LIMIT=3, write 4 words with immediate ack → addresses 0, 1, 2, 3, and the fifth word goes to 0.
- Hold under stall: ack withheld 20 cycles, 2 presses meanwhile → addr/data stable, request high throughout; presses dropped; byte_cnt_out stays 0 after completion.
- Clear: 2 bytes entered, clear_in pulse, then 4 bytes AA, BB, CC, DD → word 32'hAABBCCDD at ADDR_BASE. Clear and a press in the same cycle → byte_cnt_out=0.
- Reset mid-write: rst asserted while the request is high → next cycle the request is 0, addr_out=ADDR_BASE, no word_done_out pulse.
- Synchronizer timing: write_in_n falls → byte_cnt_out increments exactly 3 clocks later. A held key gives only 1 increment; release then re-press gives a second.

Source files
------------

// File: rtl/sw_mem_pkg.sv
// Shared definitions for the data-memory board loaders (switch writer and LCD reader).
package sw_mem_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;
    localparam int BYTE_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        WRITE   = 1'b1
    } wr_state_e;

    // True when the byte counter shows the word is one byte short of complete.
    function automatic logic is_last_byte(input logic [1:0] cnt);
        return (cnt == 2'(BYTES_PER_WORD - 1));
    endfunction

endpackage

// File: rtl/sw_mem_write_key_sync_edge.sv
// Key conditioner: two-flop synchronizer, active-low to active-high, rising-edge pulse.
// The inversion sits in front of the first flop so every flop clears to the
// "key released" level; a press is then seen three clocks after the key falls.
module key_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    logic [1:0] sync_r;
    logic       prev_r;

    // Synchronize the key level and remember the previous synchronized level.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= 2'b00;
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[0], ~key_n};
            prev_r <= sync_r[1];
        end
    end

    assign press = sync_r[1] & ~prev_r;

endmodule

// File: rtl/sw_mem_write.sv
// Switch-to-data-memory loader: four key presses assemble a word (MSB byte
// first), which is written through a request/ack port; the address then advances.
module sw_mem_write
    import sw_mem_pkg::*;
#(
    parameter int          ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int          DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned ADDR_BASE  = 32'd0,
    parameter int unsigned ADDR_LIMIT = 32'd255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  write_in_n,
    input  logic [7:0]            sw_in,
    input  logic                  clear_in,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_mem_wr_en_out,
    input  logic                  data_mem_wr_ack_in,
    output logic [1:0]            byte_cnt_out,
    output logic                  busy_out,
    output logic                  word_done_out
);

    localparam logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(ADDR_BASE);
    localparam logic [ADDR_WIDTH-1:0] LIMIT_ADDR = ADDR_WIDTH'(ADDR_LIMIT);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
    // Only the three older bytes need storing; the newest byte comes straight off the switches.
    localparam int SHIFT_WIDTH = DATA_WIDTH - BYTE_WIDTH;

    wr_state_e              state_r;
    logic [SHIFT_WIDTH-1:0] shift_r;
    logic                   press_s;
    logic [DATA_WIDTH-1:0]  word_s;
    logic [ADDR_WIDTH-1:0]  addr_next_s;

    key_sync_edge u_key (
        .clk   (clk),
        .rst   (rst),
        .key_n (write_in_n),
        .press (press_s)
    );

    // Word as it would look with the current switch byte appended, and the wrapped next address.
    always_comb begin
        word_s      = {shift_r, sw_in};
        addr_next_s = BASE_ADDR;
        if (addr_out == LIMIT_ADDR) begin
            addr_next_s = BASE_ADDR;
        end else begin
            addr_next_s = addr_out + ADDR_ONE;
        end
    end

    // Collect/write controller with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r            <= COLLECT;
            shift_r            <= {SHIFT_WIDTH{1'b0}};
            byte_cnt_out       <= 2'd0;
            addr_out           <= BASE_ADDR;
            data_out           <= {DATA_WIDTH{1'b0}};
            data_mem_wr_en_out <= 1'b0;
            busy_out           <= 1'b0;
            word_done_out      <= 1'b0;
        end else begin
            word_done_out <= 1'b0;
            case (state_r)
                COLLECT: begin
                    // Clear beats a simultaneous press: the byte is dropped.
                    if (clear_in) begin
                        byte_cnt_out <= 2'd0;
                        shift_r      <= {SHIFT_WIDTH{1'b0}};
                        addr_out     <= BASE_ADDR;
                    end else if (press_s) begin
                        shift_r <= word_s[SHIFT_WIDTH-1:0];
                        if (is_last_byte(byte_cnt_out)) begin
                            data_out           <= word_s;
                            byte_cnt_out       <= 2'd0;
                            data_mem_wr_en_out <= 1'b1;
                            busy_out           <= 1'b1;
                            state_r            <= WRITE;
                        end else begin
                            byte_cnt_out <= byte_cnt_out + 2'd1;
                        end
                    end
                end
                WRITE: begin
                    // Presses and clear are ignored here; address and data stay put until ack.
                    if (data_mem_wr_ack_in && data_mem_wr_en_out) begin
                        data_mem_wr_en_out <= 1'b0;
                        busy_out           <= 1'b0;
                        word_done_out      <= 1'b1;
                        addr_out           <= addr_next_s;
                        state_r            <= COLLECT;
                    end
                end
                default: begin
                    state_r            <= COLLECT;
                    data_mem_wr_en_out <= 1'b0;
                    busy_out           <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sw_mem_write.sv
// Bench for sw_mem_write: directed presses, scoreboard of expected writes, monitor on the request.
module tb_sw_mem_write;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        write_in_n;
    logic [7:0]  sw_in;
    logic        clear_in;
    logic [31:0] addr;
    logic [31:0] data;
    logic        wr_en;
    logic        ack;
    logic [1:0]  byte_cnt;
    logic        busy;
    logic        done;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    exp_t cur_exp;
    logic wr_prev = 1'b0;
    logic hs_prev = 1'b0;

    sw_mem_write #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .ADDR_BASE  (32'd0),
        .ADDR_LIMIT (32'd3)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .write_in_n         (write_in_n),
        .sw_in              (sw_in),
        .clear_in           (clear_in),
        .addr_out           (addr),
        .data_out           (data),
        .data_mem_wr_en_out (wr_en),
        .data_mem_wr_ack_in (ack),
        .byte_cnt_out       (byte_cnt),
        .busy_out           (busy),
        .word_done_out      (done)
    );

    always #10 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Advance n clocks; inputs change and direct checks happen 2 ns after the edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // One clean key press: accepted on the third edge, then released and settled.
    task automatic press(input logic [7:0] b);
        cyc(1);
        sw_in      = b;
        write_in_n = 1'b0;
        cyc(5);
        write_in_n = 1'b1;
        cyc(4);
    endtask

    task automatic ack_pulse(input logic [31:0] next_addr, input string tag);
        ack = 1'b1;
        cyc(1);
        ack = 1'b0;
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_req_low"}, {31'd0, wr_en}, 32'd0);
        check({tag, "_busy_low"}, {31'd0, busy}, 32'd0);
        check({tag, "_addr"}, addr, next_addr);
        check({tag, "_cnt"}, {30'd0, byte_cnt}, 32'd0);
        cyc(1);
        check({tag, "_done_1cyc"}, {31'd0, done}, 32'd0);
    endtask

    // Monitor: pop an expectation on each new request, hold it stable while stalled,
    // and require a done pulse exactly one cycle after each handshake.
    always @(negedge clk) begin
        if (wr_en === 1'b1 && wr_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write_req", 32'd1, 32'd0);
            end else begin
                cur_exp = exp_q.pop_front();
                check("write_addr", addr, cur_exp.addr);
                check("write_data", data, cur_exp.data);
            end
        end else if (wr_en === 1'b1) begin
            check("held_addr", addr, cur_exp.addr);
            check("held_data", data, cur_exp.data);
        end
        if (done === 1'b1 || hs_prev === 1'b1) begin
            check("word_done_after_ack", {31'd0, done}, {31'd0, hs_prev});
        end
        wr_prev <= wr_en;
        hs_prev <= (wr_en === 1'b1) && (ack === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] words [5];
        logic [31:0] waddr [5];
        logic [31:0] w;
        words = '{32'h00010203, 32'h04050607, 32'h08090A0B, 32'h0C0D0E0F, 32'h10111213};
        waddr = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};

        rst        = 1'b1;
        write_in_n = 1'b1;
        sw_in      = 8'h00;
        clear_in   = 1'b0;
        ack        = 1'b0;
        cyc(3);
        check("rst_addr", addr, 32'd0);
        check("rst_data", data, 32'd0);
        check("rst_req", {31'd0, wr_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_cnt", {30'd0, byte_cnt}, 32'd0);
        rst = 1'b0;
        cyc(2);

        // Synchronizer latency and held-key behaviour on the first byte.
        cyc(1);
        sw_in      = 8'h12;
        write_in_n = 1'b0;
        cyc(2);
        check("sync_lat_2clk", {30'd0, byte_cnt}, 32'd0);
        cyc(1);
        check("sync_lat_3clk", {30'd0, byte_cnt}, 32'd1);
        cyc(8);
        check("held_key_single", {30'd0, byte_cnt}, 32'd1);
        write_in_n = 1'b1;
        cyc(4);
        press(8'h34);
        check("repress_second", {30'd0, byte_cnt}, 32'd2);

        // Basic word.
        press(8'h56);
        check("basic_cnt3", {30'd0, byte_cnt}, 32'd3);
        push_exp(32'd0, 32'h12345678);
        press(8'h78);
        check("basic_req", {31'd0, wr_en}, 32'd1);
        check("basic_busy", {31'd0, busy}, 32'd1);
        ack_pulse(32'd1, "basic");

        // Stall: ack withheld over 20 cycles, two presses dropped.
        press(8'h01);
        press(8'h02);
        press(8'h03);
        push_exp(32'd1, 32'h01020304);
        press(8'h04);
        press(8'hEE);
        press(8'hFF);
        cyc(4);
        check("stall_req_high", {31'd0, wr_en}, 32'd1);
        check("stall_busy", {31'd0, busy}, 32'd1);
        check("stall_cnt", {30'd0, byte_cnt}, 32'd0);
        ack_pulse(32'd2, "stall");

        // Clear drops partial bytes and rewinds the address.
        press(8'h11);
        press(8'h22);
        check("clear_pre_cnt", {30'd0, byte_cnt}, 32'd2);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        check("clear_cnt", {30'd0, byte_cnt}, 32'd0);
        check("clear_addr", addr, 32'd0);
        press(8'hAA);
        press(8'hBB);
        press(8'hCC);
        push_exp(32'd0, 32'hAABBCCDD);
        press(8'hDD);
        ack_pulse(32'd1, "clear_word");

        // Clear in the same cycle a press is accepted.
        cyc(1);
        sw_in      = 8'h99;
        write_in_n = 1'b0;
        cyc(2);
        clear_in = 1'b1;
        cyc(1);
        clear_in = 1'b0;
        check("clear_wins_cnt", {30'd0, byte_cnt}, 32'd0);
        check("clear_wins_addr", addr, 32'd0);
        write_in_n = 1'b1;
        cyc(4);

        // Wrap with ADDR_LIMIT=3 and ack held high (one-cycle writes).
        ack = 1'b1;
        for (int i = 0; i < 5; i++) begin
            w = words[i];
            push_exp(waddr[i], w);
            press(w[31:24]);
            press(w[23:16]);
            press(w[15:8]);
            press(w[7:0]);
        end
        ack = 1'b0;
        cyc(1);
        check("wrap_next_addr", addr, 32'd1);

        // Reset while a request is outstanding.
        push_exp(32'd1, 32'h5A5A5A5A);
        for (int i = 0; i < 4; i++) begin
            press(8'h5A);
        end
        check("midrst_req_before", {31'd0, wr_en}, 32'd1);
        rst = 1'b1;
        cyc(1);
        check("midrst_req", {31'd0, wr_en}, 32'd0);
        check("midrst_addr", addr, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        cyc(3);
        check("midrst_no_done", {31'd0, done}, 32'd0);
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
